id_stage_p: RTL and testbench



---
 rtl/id_stage_p_if.sv | 52 +++++
 rtl/id_stage_p.sv | 192 +++++++++++++++++++
 tb/tb_id_stage_p.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_p_if.sv
// Decode-stage bundle: IF/ID slot, write-back port, EX feedback, and the registered ID/EX outputs.
// master drives the IF/ID, WB and EX-feedback side; slave is the decode stage itself.
interface id_stage_p_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] PC_ID;
  logic [31:0]     INSTRUCTION_ID;
  logic            VALID_ID;
  logic            RegWrite_WB;
  logic [4:0]      RD_WB;
  logic [XLEN-1:0] ALU_DATA_WB;
  logic [4:0]      RD_EX;
  logic            MemRead_EX;
  logic            FLUSH_EX;

  logic [XLEN-1:0] PC_EX;
  logic [XLEN-1:0] IMM_EX;
  logic [XLEN-1:0] REG_DATA1_EX;
  logic [XLEN-1:0] REG_DATA2_EX;
  logic [2:0]      FUNCT3_EX;
  logic [6:0]      FUNCT7_EX;
  logic [4:0]      RD_IDEX;
  logic [4:0]      RS1_IDEX;
  logic [4:0]      RS2_IDEX;
  logic            VALID_EX;
  logic            RegWrite_EX;
  logic            MemtoReg_EX;
  logic            MemRead_EX_o;
  logic            MemWrite_EX;
  logic            Branch_EX;
  logic            ALUSrc_EX;
  logic [1:0]      ALUop_EX;
  logic            PC_write;
  logic            IF_ID_Write;
  logic [15:0]     STALL_CNT;

  modport master (
    output PC_ID, INSTRUCTION_ID, VALID_ID, RegWrite_WB, RD_WB, ALU_DATA_WB,
           RD_EX, MemRead_EX, FLUSH_EX,
    input  PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX, FUNCT3_EX, FUNCT7_EX,
           RD_IDEX, RS1_IDEX, RS2_IDEX, VALID_EX, RegWrite_EX, MemtoReg_EX,
           MemRead_EX_o, MemWrite_EX, Branch_EX, ALUSrc_EX, ALUop_EX,
           PC_write, IF_ID_Write, STALL_CNT
  );

  modport slave (
    input  PC_ID, INSTRUCTION_ID, VALID_ID, RegWrite_WB, RD_WB, ALU_DATA_WB,
           RD_EX, MemRead_EX, FLUSH_EX,
    output PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX, FUNCT3_EX, FUNCT7_EX,
           RD_IDEX, RS1_IDEX, RS2_IDEX, VALID_EX, RegWrite_EX, MemtoReg_EX,
           MemRead_EX_o, MemWrite_EX, Branch_EX, ALUSrc_EX, ALUop_EX,
           PC_write, IF_ID_Write, STALL_CNT
  );
endinterface

// File: rtl/id_stage_p.sv
// RISC-V decode stage: control decode, immediate, register file, load-use stall FSM, ID/EX register.
// Latency: 1 cycle to ID/EX. Backpressure: PC_write/IF_ID_Write drop while a load-use stall is held.
module id_stage_p #(
  parameter int XLEN       = 32,
  parameter int REG_COUNT  = 32,
  parameter int LOAD_STALL = 1,
  parameter int WB_BYPASS  = 1
) (
  input logic         clk,
  input logic         reset,
  id_stage_p_if.slave bus
);
  localparam int         AW        = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [5:0] RC        = 6'(REG_COUNT);
  localparam logic [1:0] HOLD_INIT = 2'(LOAD_STALL - 1);

  typedef enum logic {RUN, HOLD} state_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctl_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
  } idex_t;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [15:0]     stall_cnt_q;
  idex_t           idex_q;
  ctl_t            ctl_q;
  logic            valid_q;
  logic [XLEN-1:0] rf_q [REG_COUNT];

  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [4:0]      ridx [2];
  logic [XLEN-1:0] rdat [2];
  ctl_t            ctl;
  logic [XLEN-1:0] imm;
  logic            wb_hit;
  logic            hit;
  logic            stall;

  assign inst    = bus.INSTRUCTION_ID;
  assign opcode  = inst[6:0];
  assign ridx[0] = inst[19:15];
  assign ridx[1] = inst[24:20];

  always_comb begin
    ctl = '0;
    imm = '0;
    case (opcode)
      7'b0110011: begin
        ctl.reg_write = 1'b1;
        ctl.alu_op    = 2'b10;
      end
      7'b0010011: begin
        ctl.alu_src   = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.alu_op    = 2'b10;
        imm           = {{(XLEN-12){inst[31]}}, inst[31:20]};
      end
      7'b0000011: begin
        ctl.alu_src    = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
        ctl.mem_read   = 1'b1;
        imm            = {{(XLEN-12){inst[31]}}, inst[31:20]};
      end
      7'b0100011: begin
        ctl.alu_src   = 1'b1;
        ctl.mem_write = 1'b1;
        imm           = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      end
      7'b1100011: begin
        ctl.branch = 1'b1;
        ctl.alu_op = 2'b01;
        imm        = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      default: ;
    endcase
  end

  // Out-of-range indices are never written, so they are also masked to zero on read.
  assign wb_hit = bus.RegWrite_WB && (bus.RD_WB != 5'd0) && ({1'b0, bus.RD_WB} < RC);

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdat[p] = '0;
      if ((ridx[p] != 5'd0) && ({1'b0, ridx[p]} < RC)) begin
        if ((WB_BYPASS != 0) && wb_hit && (bus.RD_WB == ridx[p])) rdat[p] = bus.ALU_DATA_WB;
        else                                                      rdat[p] = rf_q[ridx[p][AW-1:0]];
      end
    end
  end

  assign hit = bus.VALID_ID && bus.MemRead_EX && (bus.RD_EX != 5'd0) &&
               ((bus.RD_EX == ridx[0]) || (bus.RD_EX == ridx[1]));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (bus.FLUSH_EX) begin
      state_d = RUN;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (hit) begin
            stall = 1'b1;
            if (LOAD_STALL > 1) begin
              state_d = HOLD;
              cnt_d   = HOLD_INIT;
            end
          end
        end
        HOLD: begin
          stall = 1'b1;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      cnt_q       <= 2'd0;
      stall_cnt_q <= 16'd0;
      idex_q      <= '0;
      ctl_q       <= '0;
      valid_q     <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (wb_hit) rf_q[bus.RD_WB[AW-1:0]] <= bus.ALU_DATA_WB;
      if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      // Bubbles clear only valid and controls; data fields keep their last values.
      if (stall || bus.FLUSH_EX) begin
        valid_q <= 1'b0;
        ctl_q   <= '0;
      end else begin
        valid_q <= bus.VALID_ID;
        ctl_q   <= bus.VALID_ID ? ctl : '0;
        idex_q  <= '{pc: bus.PC_ID, imm: imm, rd1: rdat[0], rd2: rdat[1],
                     f3: inst[14:12], f7: inst[31:25], rd: inst[11:7],
                     rs1: ridx[0], rs2: ridx[1]};
      end
    end
  end

  assign bus.PC_EX        = idex_q.pc;
  assign bus.IMM_EX       = idex_q.imm;
  assign bus.REG_DATA1_EX = idex_q.rd1;
  assign bus.REG_DATA2_EX = idex_q.rd2;
  assign bus.FUNCT3_EX    = idex_q.f3;
  assign bus.FUNCT7_EX    = idex_q.f7;
  assign bus.RD_IDEX      = idex_q.rd;
  assign bus.RS1_IDEX     = idex_q.rs1;
  assign bus.RS2_IDEX     = idex_q.rs2;
  assign bus.VALID_EX     = valid_q;
  assign bus.RegWrite_EX  = ctl_q.reg_write;
  assign bus.MemtoReg_EX  = ctl_q.mem_to_reg;
  assign bus.MemRead_EX_o = ctl_q.mem_read;
  assign bus.MemWrite_EX  = ctl_q.mem_write;
  assign bus.Branch_EX    = ctl_q.branch;
  assign bus.ALUSrc_EX    = ctl_q.alu_src;
  assign bus.ALUop_EX     = ctl_q.alu_op;
  assign bus.PC_write     = ~stall;
  assign bus.IF_ID_Write  = ~stall;
  assign bus.STALL_CNT    = stall_cnt_q;
endmodule

// File: tb/tb_id_stage_p.sv
// Bench for id_stage_p: decode vector table, directed hazard/flush/reset sequences, and a random run against a reference model.
module tb_id_stage_p;
  localparam int LS_A = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_stage_p_if #(.XLEN(32)) ia ();
  id_stage_p_if #(.XLEN(32)) ib ();

  id_stage_p #(.XLEN(32), .REG_COUNT(32), .LOAD_STALL(LS_A), .WB_BYPASS(1))
    dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
  id_stage_p #(.XLEN(32), .REG_COUNT(16), .LOAD_STALL(1), .WB_BYPASS(0))
    dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

  typedef struct packed {
    logic [31:0] pc, imm, rd1, rd2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic        valid;
    logic [7:0]  ctl;   // {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, ALUop[1:0]}
    logic [15:0] scnt;
  } out_t;

  typedef struct {
    logic [31:0] inst;
    logic        v;
    logic [7:0]  ctl;
    logic [31:0] imm;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] i_pc, i_inst, i_wbd;
  logic        i_valid, i_rw, i_mr, i_flush;
  logic [4:0]  i_rdwb, i_rdex;

  logic [31:0] m_rf [32];
  int          m_left;
  out_t        m_out;
  logic        exp_pcw;

  function automatic out_t get_a();
    return {ia.PC_EX, ia.IMM_EX, ia.REG_DATA1_EX, ia.REG_DATA2_EX, ia.FUNCT3_EX, ia.FUNCT7_EX,
            ia.RD_IDEX, ia.RS1_IDEX, ia.RS2_IDEX, ia.VALID_EX, ia.RegWrite_EX, ia.MemtoReg_EX,
            ia.MemRead_EX_o, ia.MemWrite_EX, ia.Branch_EX, ia.ALUSrc_EX, ia.ALUop_EX, ia.STALL_CNT};
  endfunction

  function automatic out_t get_b();
    return {ib.PC_EX, ib.IMM_EX, ib.REG_DATA1_EX, ib.REG_DATA2_EX, ib.FUNCT3_EX, ib.FUNCT7_EX,
            ib.RD_IDEX, ib.RS1_IDEX, ib.RS2_IDEX, ib.VALID_EX, ib.RegWrite_EX, ib.MemtoReg_EX,
            ib.MemRead_EX_o, ib.MemWrite_EX, ib.Branch_EX, ib.ALUSrc_EX, ib.ALUop_EX, ib.STALL_CNT};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a();
    ia.PC_ID = i_pc; ia.INSTRUCTION_ID = i_inst; ia.VALID_ID = i_valid;
    ia.RegWrite_WB = i_rw; ia.RD_WB = i_rdwb; ia.ALU_DATA_WB = i_wbd;
    ia.RD_EX = i_rdex; ia.MemRead_EX = i_mr; ia.FLUSH_EX = i_flush;
  endtask

  task automatic idle_a();
    i_pc = '0; i_inst = '0; i_valid = 1'b0; i_rw = 1'b0; i_rdwb = '0; i_wbd = '0;
    i_rdex = '0; i_mr = 1'b0; i_flush = 1'b0;
    drive_a();
  endtask

  task automatic idle_b();
    ib.PC_ID = '0; ib.INSTRUCTION_ID = '0; ib.VALID_ID = 1'b0; ib.RegWrite_WB = 1'b0;
    ib.RD_WB = '0; ib.ALU_DATA_WB = '0; ib.RD_EX = '0; ib.MemRead_EX = 1'b0; ib.FLUSH_EX = 1'b0;
  endtask

  function automatic logic [7:0] ref_ctl(input logic [6:0] op);
    case (op)
      7'b0110011: return 8'b1000_0010;
      7'b0010011: return 8'b1000_0110;
      7'b0000011: return 8'b1110_0100;
      7'b0100011: return 8'b0001_0100;
      7'b1100011: return 8'b0000_1001;
      default:    return 8'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] x);
    case (x[6:0])
      7'b0000011, 7'b0010011: return 32'($signed(x[31:20]));
      7'b0100011: return 32'($signed({x[31:25], x[11:7]}));
      7'b1100011: return 32'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
      default:    return 32'd0;
    endcase
  endfunction

  // Reference for dut_a: stalls are a count of remaining bubble cycles, not a state machine.
  task automatic model_step();
    logic       wr, hit, stall;
    logic [4:0] s1, s2;
    s1  = i_inst[19:15];
    s2  = i_inst[24:20];
    hit = i_valid && i_mr && (i_rdex != 0) && (i_rdex == s1 || i_rdex == s2);
    wr  = i_rw && (i_rdwb != 0);
    if (i_flush)         begin stall = 1'b0; m_left = 0; end
    else if (m_left > 0) begin stall = 1'b1; m_left--; end
    else if (hit)        begin stall = 1'b1; m_left = LS_A - 1; end
    else                       stall = 1'b0;
    exp_pcw = !stall;
    if (stall || i_flush) begin
      m_out.valid = 1'b0;
      m_out.ctl   = '0;
    end else begin
      m_out.pc    = i_pc;
      m_out.imm   = ref_imm(i_inst);
      m_out.rd1   = (s1 == 0) ? 32'd0 : (wr && i_rdwb == s1) ? i_wbd : m_rf[s1];
      m_out.rd2   = (s2 == 0) ? 32'd0 : (wr && i_rdwb == s2) ? i_wbd : m_rf[s2];
      m_out.f3    = i_inst[14:12];
      m_out.f7    = i_inst[31:25];
      m_out.rd    = i_inst[11:7];
      m_out.rs1   = s1;
      m_out.rs2   = s2;
      m_out.valid = i_valid;
      m_out.ctl   = i_valid ? ref_ctl(i_inst[6:0]) : 8'd0;
    end
    if (stall && m_out.scnt != 16'hFFFF) m_out.scnt = m_out.scnt + 16'd1;
    if (wr) m_rf[i_rdwb] = i_wbd;
  endtask

  vec_t tbl [11];
  out_t o;

  initial begin
    tbl[0]  = '{32'h00128313, 1'b1, 8'h86, 32'h00000001};  // addi x6,x5,1
    tbl[1]  = '{32'hFFF00093, 1'b1, 8'h86, 32'hFFFFFFFF};  // addi x1,x0,-1
    tbl[2]  = '{32'hFFC0A103, 1'b1, 8'hE4, 32'hFFFFFFFC};  // lw x2,-4(x1)
    tbl[3]  = '{32'h0020A423, 1'b1, 8'h14, 32'h00000008};  // sw x2,8(x1)
    tbl[4]  = '{32'hFE002823, 1'b1, 8'h14, 32'hFFFFFFF0};  // sw x0,-16(x0)
    tbl[5]  = '{32'h00208463, 1'b1, 8'h09, 32'h00000008};  // beq x1,x2,+8
    tbl[6]  = '{32'hFE001EE3, 1'b1, 8'h09, 32'hFFFFFFFC};  // bne x0,x0,-4
    tbl[7]  = '{32'h002081B3, 1'b1, 8'h82, 32'h00000000};  // add x3,x1,x2
    tbl[8]  = '{32'hFFFFFFFF, 1'b1, 8'h00, 32'h00000000};  // opcode 1111111
    tbl[9]  = '{32'h00128313, 1'b0, 8'h00, 32'h00000001};  // invalid slot
    tbl[10] = '{32'h12345037, 1'b1, 8'h00, 32'h00000000};  // lui: unsupported

    reset = 1'b1;
    idle_a();
    idle_b();
    // Reset beats a pending hazard and a write-back.
    i_inst = 32'h00018233; i_valid = 1'b1; i_mr = 1'b1; i_rdex = 5'd3;
    i_rw = 1'b1; i_rdwb = 5'd5; i_wbd = 32'hDEAD;
    drive_a();
    #1;
    chk("rst_pcw", {ia.PC_write, ia.IF_ID_Write}, 2'b11);
    tick();
    tick();
    chk("rst_out_a", get_a(), '0);
    chk("rst_out_b", get_b(), '0);
    reset = 1'b0;
    idle_a();
    i_inst = 32'h00028433; i_valid = 1'b1;  // add x8,x5,x0
    drive_a();
    tick();
    chk("rst_rf_x5", ia.REG_DATA1_EX, 32'd0);

    for (int k = 0; k < 11; k++) begin
      idle_a();
      i_inst = tbl[k].inst; i_valid = tbl[k].v; i_pc = 32'h100 + 32'(k * 4);
      drive_a();
      tick();
      o = get_a();
      chk($sformatf("dec%0d", k), {o.valid, o.ctl, o.imm, o.pc}, {tbl[k].v, tbl[k].ctl, tbl[k].imm, i_pc});
    end

    // Write x5 then decode addi x6,x5,1.
    idle_a();
    i_rw = 1'b1; i_rdwb = 5'd5; i_wbd = 32'h1234;
    drive_a();
    tick();
    idle_a();
    i_inst = 32'h00128313; i_valid = 1'b1;
    drive_a();
    tick();
    o = get_a();
    chk("addi_rd1", o.rd1, 32'h1234);
    chk("addi_imm_ctl", {o.imm, o.ctl[2], o.ctl[1:0]}, {32'd1, 1'b1, 2'b10});

    // Same-cycle WB forwarding: on for dut_a, off for dut_b.
    idle_a();
    i_rw = 1'b1; i_rdwb = 5'd7; i_wbd = 32'hABCD; i_inst = 32'h00038433; i_valid = 1'b1;
    drive_a();
    ib.RegWrite_WB = 1'b1; ib.RD_WB = 5'd7; ib.ALU_DATA_WB = 32'h1111;
    tick();
    chk("byp_on", ia.REG_DATA1_EX, 32'hABCD);
    ib.ALU_DATA_WB = 32'hABCD; ib.INSTRUCTION_ID = 32'h00038433; ib.VALID_ID = 1'b1;
    tick();
    chk("byp_off_old", ib.REG_DATA1_EX, 32'h1111);
    ib.RegWrite_WB = 1'b0;
    tick();
    chk("byp_off_new", ib.REG_DATA1_EX, 32'hABCD);

    // x0 stays zero even when targeted by a write.
    idle_a();
    i_rw = 1'b1; i_rdwb = 5'd0; i_wbd = 32'hFFFFFFFF; i_inst = 32'h00000433; i_valid = 1'b1;
    drive_a();
    tick();
    chk("x0_same", ia.REG_DATA1_EX, 32'd0);
    i_rw = 1'b0;
    drive_a();
    tick();
    chk("x0_after", ia.REG_DATA1_EX, 32'd0);

    // dut_b has 16 entries: x20 is out of range.
    idle_b();
    ib.RegWrite_WB = 1'b1; ib.RD_WB = 5'd20; ib.ALU_DATA_WB = 32'h55;
    tick();
    ib.RegWrite_WB = 1'b0; ib.INSTRUCTION_ID = 32'h014A0433; ib.VALID_ID = 1'b1;
    tick();
    chk("oor_read", {ib.REG_DATA1_EX, ib.REG_DATA2_EX, ib.RS1_IDEX}, {64'd0, 5'd20});
    idle_b();

    // Load-use with two bubbles.
    reset = 1'b1;
    idle_a();
    tick();
    reset = 1'b0;
    i_inst = 32'h00018233; i_valid = 1'b1; i_mr = 1'b1; i_rdex = 5'd3;
    drive_a();
    #1;
    chk("ls_pcw0", {ia.PC_write, ia.IF_ID_Write}, 2'b00);
    tick();
    chk("ls_bub0", {ia.VALID_EX, ia.RegWrite_EX, ia.STALL_CNT}, {2'b00, 16'd1});
    i_mr = 1'b0;
    drive_a();
    #1;
    chk("ls_pcw1", {ia.PC_write, ia.IF_ID_Write}, 2'b00);
    tick();
    chk("ls_bub1", {ia.VALID_EX, ia.STALL_CNT}, {1'b0, 16'd2});
    #1;
    chk("ls_pcw2", {ia.PC_write, ia.IF_ID_Write}, 2'b11);
    tick();
    chk("ls_issue", {ia.VALID_EX, ia.RS1_IDEX, ia.RegWrite_EX, ia.STALL_CNT}, {1'b1, 5'd3, 1'b1, 16'd2});

    // Flush during HOLD.
    i_mr = 1'b1;
    drive_a();
    tick();
    i_mr = 1'b0; i_flush = 1'b1;
    drive_a();
    #1;
    chk("fl_pcw", {ia.PC_write, ia.IF_ID_Write}, 2'b11);
    tick();
    chk("fl_bub", {ia.VALID_EX, ia.STALL_CNT}, {1'b0, 16'd3});
    i_flush = 1'b0;
    drive_a();
    #1;
    chk("fl_run_pcw", ia.PC_write, 1'b1);
    tick();
    chk("fl_issue", {ia.VALID_EX, ia.STALL_CNT}, {1'b1, 16'd3});

    // Reset while in HOLD drops the remaining stall.
    i_mr = 1'b1;
    drive_a();
    tick();
    i_mr = 1'b0;
    reset = 1'b1;
    drive_a();
    #1;
    chk("rh_pcw", {ia.PC_write, ia.IF_ID_Write}, 2'b11);
    tick();
    chk("rh_out", get_a(), '0);
    reset = 1'b0;
    #1;
    chk("rh_pcw_after", ia.PC_write, 1'b1);
    tick();
    chk("rh_issue", {ia.VALID_EX, ia.STALL_CNT}, {1'b1, 16'd0});

    // Random run against the model.
    reset = 1'b1;
    idle_a();
    tick();
    reset = 1'b0;
    for (int r = 0; r < 32; r++) m_rf[r] = '0;
    m_left = 0;
    m_out  = '0;
    for (int n = 0; n < 3000; n++) begin
      i_inst = $urandom;
      case ($urandom_range(0, 5))
        0: i_inst[6:0] = 7'b0110011;
        1: i_inst[6:0] = 7'b0010011;
        2: i_inst[6:0] = 7'b0000011;
        3: i_inst[6:0] = 7'b0100011;
        4: i_inst[6:0] = 7'b1100011;
        default: ;
      endcase
      i_inst[19:15] = 5'($urandom_range(0, 7));
      i_inst[24:20] = 5'($urandom_range(0, 7));
      i_pc    = $urandom;
      i_valid = ($urandom_range(0, 9) != 0);
      i_rw    = $urandom_range(0, 1) == 1;
      i_rdwb  = 5'($urandom_range(0, 7));
      i_wbd   = $urandom;
      i_rdex  = 5'($urandom_range(0, 7));
      i_mr    = ($urandom_range(0, 2) == 0);
      i_flush = ($urandom_range(0, 9) == 0);
      drive_a();
      model_step();
      #1;
      chk("rnd_pcw", {ia.PC_write, ia.IF_ID_Write}, {exp_pcw, exp_pcw});
      tick();
      chk("rnd_out", get_a(), m_out);
    end
    idle_a();

    // STALL_CNT saturation on dut_b (one bubble per hazard, hazard held every cycle).
    ib.INSTRUCTION_ID = 32'h00018233; ib.VALID_ID = 1'b1; ib.MemRead_EX = 1'b1; ib.RD_EX = 5'd3;
    ib.RegWrite_WB = 1'b1; ib.RD_WB = 5'd7; ib.ALU_DATA_WB = 32'h77;
    repeat (65534) tick();
    chk("sat_fffe", ib.STALL_CNT, 16'hFFFE);
    tick();
    chk("sat_ffff", ib.STALL_CNT, 16'hFFFF);
    tick();
    tick();
    chk("sat_hold", {ib.STALL_CNT, ib.PC_write}, {16'hFFFF, 1'b0});
    ib.RegWrite_WB = 1'b0; ib.MemRead_EX = 1'b0; ib.INSTRUCTION_ID = 32'h00038433;
    tick();
    chk("sat_x7", {ib.REG_DATA1_EX, ib.VALID_EX}, {32'h77, 1'b1});
    reset = 1'b1;
    tick();
    chk("sat_rst", get_b(), '0);
    reset = 1'b0;
    tick();
    chk("rst_rf_x7", {ib.REG_DATA1_EX, ib.VALID_EX}, {32'd0, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
